// File: rtl/srseq_pkg.sv
// Shared types and the excitation lookup for the srff drive sequencer.
package srseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  // Packed pair, MSB first, so the value reads as {s, r}.
  typedef struct packed {
    logic s;
    logic r;
  } sr_t;

  // Excitation for an srff moving from q to tgt. The single don't-care input
  // of each hold case is filled with dc_fill. That input is never the one
  // opposite the asserted drive, so s=r=1 cannot be produced.
  function automatic sr_t exc_dc(input logic q, input logic tgt, input logic dc_fill);
    sr_t e;
    unique case ({q, tgt})
      2'b00: begin e.s = 1'b0;    e.r = dc_fill; end
      2'b01: begin e.s = 1'b1;    e.r = 1'b0;    end
      2'b10: begin e.s = 1'b0;    e.r = 1'b1;    end
      default: begin e.s = dc_fill; e.r = 1'b0;  end
    endcase
    return e;
  endfunction

  // Plain lookup with don't-cares driven low; returns {s, r}.
  function automatic sr_t exc(input logic q, input logic tgt);
    return exc_dc(q, tgt, 1'b0);
  endfunction

endpackage

// File: rtl/sr_tgt_fifo.sv
// Small synchronous 1-bit FIFO holding target q values awaiting the sequencer.
module sr_tgt_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [DEPTH-1:0] mem_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // Next pointer values; simultaneous push and pop both advance.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is data only and needs no reset: the pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sr_drive_sequencer.sv
// Turns a stream of desired srff q values into s/r excitation, then checks
// the flop's fed-back q against each target and counts completions/failures.
module sr_drive_sequencer
  import srseq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int DC_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  output logic             busy,
  output logic             bit_done,
  output logic             mismatch,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Hold-last is reserved; both settings currently fill don't-cares with 0.
  localparam logic DC_FILL = (DC_HOLD != 0) ? 1'b0 : 1'b0;

  state_e           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             bit_done_q, bit_done_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             pop;
  logic             push;
  logic             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  sr_t              sr_nxt;

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign push = tgt_valid && tgt_ready;

  sr_tgt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (tgt_bit),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sr_nxt = exc_dc(q_fb, tgt_q, DC_FILL);

  // Sequencer: IDLE -> DRIVE -> SETTLE -> CHECK, looping straight back to
  // DRIVE while targets are queued so each bit costs three cycles.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    pop        = 1'b0;
    bit_done_d = 1'b0;
    mismatch_d = mismatch_q;
    done_d     = done_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          tgt_d   = fifo_head;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // q_fb still reflects the flop before this bit's excitation.
        s_d     = sr_nxt.s;
        r_d     = sr_nxt.r;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The srff captures s/r on this edge; drive returns to 0 behind it.
        state_d = ST_CHECK;
      end
      default: begin
        bit_done_d = 1'b1;
        done_d     = sat_inc(done_q);
        if (q_fb != tgt_q) begin
          err_d      = sat_inc(err_q);
          mismatch_d = 1'b1;
        end
        if (!fifo_empty) begin
          pop     = 1'b1;
          tgt_d   = fifo_head;
          state_d = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Control, drive and status registers; reset drops s/r immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      bit_done_q <= 1'b0;
      mismatch_q <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      r_q        <= r_d;
      bit_done_q <= bit_done_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Current target bit; pure data, only meaningful outside IDLE.
  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
  end

  assign tgt_ready = !fifo_full;
  assign s         = s_q;
  assign r         = r_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign bit_done  = bit_done_q;
  assign mismatch  = mismatch_q;
  assign done_cnt  = done_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Bench for sr_drive_sequencer: a behavioural srff closes the s/r -> q loop,
// a scoreboard queue carries the expected outcome of every accepted target.
module tb_sr_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tgt_valid, tgt_bit, tgt_ready, s, r, q_fb, busy, bit_done, mismatch;
  logic [7:0] done_cnt, err_cnt;
  logic       tgt_valid2, tgt_bit2, tgt_ready2, s2, r2, busy2, bit_done2, mismatch2;
  logic [1:0] done_cnt2, err_cnt2;
  logic       ff_q, stuck;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int sr_viol = 0;
  int rdy_low = 0;
  int done2_n = 0;

  typedef struct packed { logic q; logic [7:0] dn; logic [7:0] er; logic mm; } obs_t;
  typedef struct packed { logic b; logic chk_q; logic [7:0] dn; logic [7:0] er; logic mm; } exp_t;
  typedef struct packed { int c; logic s; logic r; } srev_t;

  obs_t  obs_q[$];
  exp_t  exp_q[$];
  srev_t sr_log[$];
  logic [7:0] m_done, m_err;
  logic       m_mm;

  always #5 clk = ~clk;

  sr_drive_sequencer #(.DEPTH(4), .CNT_W(8), .DC_HOLD(0)) dut (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(tgt_ready), .s(s), .r(r), .q_fb(q_fb), .busy(busy),
    .bit_done(bit_done), .mismatch(mismatch), .done_cnt(done_cnt), .err_cnt(err_cnt)
  );

  sr_drive_sequencer #(.DEPTH(4), .CNT_W(2), .DC_HOLD(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid2), .tgt_bit(tgt_bit2),
    .tgt_ready(tgt_ready2), .s(s2), .r(r2), .q_fb(1'b0), .busy(busy2),
    .bit_done(bit_done2), .mismatch(mismatch2), .done_cnt(done_cnt2), .err_cnt(err_cnt2)
  );

  // Behavioural srff; stuck disconnects it from the feedback path.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ff_q <= 1'b0;
    else if (s && !r)     ff_q <= 1'b1;
    else if (r && !s)     ff_q <= 1'b0;
  end
  assign q_fb = stuck ? 1'b0 : ff_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Observers: invariant, ready stalls, completed bits and s/r activity.
  always @(negedge clk) begin
    if ((s && r) || (s2 && r2)) sr_viol <= sr_viol + 1;
    if (!tgt_ready) rdy_low <= rdy_low + 1;
    if (bit_done2) done2_n <= done2_n + 1;
    if (bit_done) obs_q.push_back({q_fb, done_cnt, err_cnt, mismatch});
    if (s || r) sr_log.push_back({cyc, s, r});
  end

  // Offer one bit, wait for it to transfer, and record its expected outcome.
  task automatic push_bit(input logic b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    tgt_valid = 1'b1;
    tgt_bit   = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = tgt_ready;
      @(posedge clk);
      #1;
      n++;
    end
    tgt_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_accept: accepted=%0b required=1 (bit %0b)", acc, b);
    end else begin
      m_done = (m_done == 8'hFF) ? m_done : m_done + 8'd1;
      if (stuck && b) begin
        m_err = (m_err == 8'hFF) ? m_err : m_err + 8'd1;
        m_mm  = 1'b1;
      end
      exp_q.push_back({b, !stuck, m_done, m_err, m_mm});
    end
  endtask

  // Run until the sequencer has gone quiet; reports whether the budget ran out.
  task automatic wait_idle(input int budget, output logic to);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((busy || bit_done) && n < budget);
    to = (n >= budget);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s, r, tgt_ready, busy, bit_done, mismatch, done_cnt, err_cnt} !== {5'b00100, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_held: got %h required %h",
               {s, r, tgt_ready, busy, bit_done, mismatch, done_cnt, err_cnt}, {5'b00100, 1'b0, 16'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({s, r, tgt_ready, busy, bit_done, mismatch, done_cnt, err_cnt} !== {5'b00100, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_released: got %h required %h",
               {s, r, tgt_ready, busy, bit_done, mismatch, done_cnt, err_cnt}, {5'b00100, 1'b0, 16'h0});
    end
  endtask

  task automatic test_single_bits();
    logic [3:0] tbl [4];
    logic       to;
    int         c0;
    exp_t       e;
    obs_t       o;
    // {s, r, busy, bit_done} after edges 1..4 following the push edge
    tbl[0] = 4'b0010;
    tbl[1] = 4'b1010;
    tbl[2] = 4'b0010;
    tbl[3] = 4'b0001;
    push_bit(1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({s, r, busy, bit_done} !== tbl[k]) begin
        errors++;
        $display("FAIL single1_edge%0d: {s,r,busy,bit_done} got %b required %b", k + 1, {s, r, busy, bit_done}, tbl[k]);
      end
      if (k == 2) begin
        checks++;
        if (q_fb !== 1'b1) begin
          errors++;
          $display("FAIL single1_q: got %b required 1", q_fb);
        end
      end
    end
    checks++;
    if ({done_cnt, err_cnt} !== {8'd1, 8'd0}) begin
      errors++;
      $display("FAIL single1_cnt: got %h required 0100", {done_cnt, err_cnt});
    end
    wait_idle(50, to);
    sr_log.delete();
    push_bit(1'b0);
    c0 = cyc;
    wait_idle(50, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL single0_idle: busy still %b after budget, required 0", busy);
    end
    checks++;
    if (sr_log.size() != 1) begin
      errors++;
      $display("FAIL single0_pulses: got %0d s/r pulses required 1", sr_log.size());
    end else if (sr_log[0] !== {c0 + 2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single0_pulse: got cyc %0d s%b r%b required cyc %0d s0 r1",
               sr_log[0].c, sr_log[0].s, sr_log[0].r, c0 + 2);
    end
    checks++;
    if ({q_fb, done_cnt} !== {1'b0, 8'd2}) begin
      errors++;
      $display("FAIL single0_state: {q,done} got %h required %h", {q_fb, done_cnt}, {1'b0, 8'd2});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL single_sb: no completion observed, required bit %b", e.b);
      end else begin
        o = obs_q.pop_front();
        if (o !== {e.chk_q ? e.b : 1'b0, e.dn, e.er, e.mm}) begin
          errors++;
          $display("FAIL single_sb: got %h required %h", o, {e.chk_q ? e.b : 1'b0, e.dn, e.er, e.mm});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] bits;
    logic       to;
    int         c0;
    srev_t      want [3];
    exp_t       e;
    obs_t       o;
    bits = 5'b10011;           // pushed LSB first: 1,1,0,0,1
    sr_log.delete();
    c0 = 0;
    for (int i = 0; i < 5; i++) begin
      push_bit(bits[i]);
      if (i == 0) c0 = cyc;
    end
    wait_idle(100, to);
    want[0] = {c0 + 2,  1'b1, 1'b0};
    want[1] = {c0 + 8,  1'b0, 1'b1};
    want[2] = {c0 + 14, 1'b1, 1'b0};
    checks++;
    if (sr_log.size() != 3) begin
      errors++;
      $display("FAIL b2b_pulse_count: got %0d required 3", sr_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (sr_log[i] !== want[i]) begin
          errors++;
          $display("FAIL b2b_pulse%0d: got cyc %0d s%b r%b required cyc %0d s%b r%b", i,
                   sr_log[i].c, sr_log[i].s, sr_log[i].r, want[i].c, want[i].s, want[i].r);
        end
      end
    end
    checks++;
    if ({q_fb, done_cnt, err_cnt} !== {1'b1, 8'd7, 8'd0}) begin
      errors++;
      $display("FAIL b2b_final: {q,done,err} got %h required %h", {q_fb, done_cnt, err_cnt}, {1'b1, 8'd7, 8'd0});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_sb: no completion observed, required bit %b", e.b);
      end else begin
        o = obs_q.pop_front();
        if (o !== {e.chk_q ? e.b : 1'b0, e.dn, e.er, e.mm}) begin
          errors++;
          $display("FAIL b2b_sb: got %h required %h", o, {e.chk_q ? e.b : 1'b0, e.dn, e.er, e.mm});
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] bits;
    logic       to;
    int         rdy0;
    exp_t       e;
    obs_t       o;
    bits = 8'b0100_1101;       // pushed LSB first: 1,0,1,1,0,0,1,0
    rdy0 = rdy_low;
    for (int i = 0; i < 8; i++) push_bit(bits[i]);
    wait_idle(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL full_idle: busy still %b after budget, required 0", busy);
    end
    checks++;
    if (!(rdy_low > rdy0)) begin
      errors++;
      $display("FAIL full_ready: stalled cycles %0d required >0", rdy_low - rdy0);
    end
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL full_count: completions %0d required 8", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL full_sb: no completion observed, required bit %b", e.b);
      end else begin
        o = obs_q.pop_front();
        if (o !== {e.chk_q ? e.b : 1'b0, e.dn, e.er, e.mm}) begin
          errors++;
          $display("FAIL full_sb: got %h required %h", o, {e.chk_q ? e.b : 1'b0, e.dn, e.er, e.mm});
        end
      end
    end
  endtask

  task automatic test_error_path();
    logic to;
    exp_t e;
    obs_t o;
    stuck = 1'b1;
    push_bit(1'b1);
    wait_idle(50, to);
    checks++;
    if ({mismatch, err_cnt} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL err_first: {mismatch,err} got %h required %h", {mismatch, err_cnt}, {1'b1, 8'd1});
    end
    push_bit(1'b0);
    wait_idle(50, to);
    checks++;
    if ({mismatch, err_cnt, done_cnt} !== {1'b1, 8'd1, 8'd17}) begin
      errors++;
      $display("FAIL err_sticky: {mismatch,err,done} got %h required %h",
               {mismatch, err_cnt, done_cnt}, {1'b1, 8'd1, 8'd17});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL err_sb: no completion observed, required bit %b", e.b);
      end else begin
        o = obs_q.pop_front();
        if (o !== {e.chk_q ? e.b : 1'b0, e.dn, e.er, e.mm}) begin
          errors++;
          $display("FAIL err_sb: got %h required %h", o, {e.chk_q ? e.b : 1'b0, e.dn, e.er, e.mm});
        end
      end
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [4:0] bits;
    int         n;
    int         nobs;
    bits = 5'b10101;           // 1,0,1,0,1; flop starts at 1 so bit 1 drives r
    for (int i = 0; i < 5; i++) push_bit(bits[i]);
    n = 0;
    while (!r && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (r !== 1'b1) begin
      errors++;
      $display("FAIL mid_settle: r got %b required 1", r);
    end
    #2;
    nobs = obs_q.size();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s, r, busy, bit_done, tgt_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL mid_async: {s,r,busy,bit_done,ready} got %b required 00001", {s, r, busy, bit_done, tgt_ready});
    end
    m_done = 8'd0;
    m_err  = 8'd0;
    m_mm   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({busy, tgt_ready, mismatch, done_cnt, err_cnt} !== {3'b010, 16'h0}) begin
      errors++;
      $display("FAIL mid_after: {busy,ready,mismatch,done,err} got %h required %h",
               {busy, tgt_ready, mismatch, done_cnt, err_cnt}, {3'b010, 16'h0});
    end
    checks++;
    if (obs_q.size() != nobs) begin
      errors++;
      $display("FAIL mid_no_done: completions %0d required %0d", obs_q.size(), nobs);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_saturation();
    logic acc;
    int   n;
    int   d0;
    d0 = done2_n;
    for (int i = 0; i < 5; i++) begin
      tgt_valid2 = 1'b1;
      tgt_bit2   = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
        @(negedge clk);
        acc = tgt_ready2;
        @(posedge clk);
        #1;
        n++;
      end
      tgt_valid2 = 1'b0;
    end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((busy2 || bit_done2) && n < 100);
    checks++;
    if ({done_cnt2, err_cnt2, mismatch2} !== 5'b11_11_1) begin
      errors++;
      $display("FAIL sat_counts: {done,err,mismatch} got %b required 11111", {done_cnt2, err_cnt2, mismatch2});
    end
    checks++;
    if (done2_n - d0 != 5) begin
      errors++;
      $display("FAIL sat_pulses: bit_done pulses %0d required 5", done2_n - d0);
    end
  endtask

  task automatic test_invariant();
    checks++;
    if (sr_viol != 0) begin
      errors++;
      $display("FAIL sr_exclusive: cycles with s&&r %0d required 0", sr_viol);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    tgt_valid  = 1'b0;
    tgt_bit    = 1'b0;
    tgt_valid2 = 1'b0;
    tgt_bit2   = 1'b0;
    stuck      = 1'b0;
    m_done     = 8'd0;
    m_err      = 8'd0;
    m_mm       = 1'b0;
    test_reset();
    test_single_bits();
    test_back_to_back();
    test_fifo_full();
    test_error_path();
    test_reset_mid();
    test_saturation();
    test_invariant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
